// File: rtl/cnn_mac_if.sv
// Controller <-> MAC responder bus: compute handshake, operand stream and result FIFO drain.
interface cnn_mac_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
);
    logic              mac_start;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] act_in;
    logic [DATA_W-1:0] wgt_in;
    logic              mac_done;
    logic              mem_write;
    logic [ACC_W-1:0]  result_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic              busy;

    modport master (
        output mac_start, op_valid, act_in, wgt_in, mem_write,
        input  op_ready, mac_done, result_out, fifo_empty, fifo_full, busy
    );

    modport slave (
        input  mac_start, op_valid, act_in, wgt_in, mem_write,
        output op_ready, mac_done, result_out, fifo_empty, fifo_full, busy
    );
endinterface

// File: rtl/cnn_mac_responder.sv
// CNN MAC responder: NUM_TAPS signed dot product per mac_start, results queued in a show-ahead FIFO.
// Optional build macro CNN_MAC_RELU_EN clamps negative results to zero on the way into the FIFO.
module cnn_mac_responder #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned NUM_TAPS   = 9,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    cnn_mac_if.slave bus
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_PUSH,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [TAP_W-1:0]  r_tap_cnt;
    logic [TAP_W-1:0]  w_tap_cnt_nxt;
    logic              r_op_ready;
    logic              r_mac_done;
    logic              r_busy;
    logic              w_op_ready_nxt;
    logic              w_mac_done_nxt;
    logic              w_busy_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_fire;

    logic signed [PROD_W-1:0] w_act_ext;
    logic signed [PROD_W-1:0] w_wgt_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_push_data;

    logic [ACC_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_empty;
    logic             r_full;

    // Signed product at full precision, then sign-extended to the accumulator width.
    assign w_act_ext  = {{DATA_W{bus.act_in[DATA_W-1]}}, bus.act_in};
    assign w_wgt_ext  = {{DATA_W{bus.wgt_in[DATA_W-1]}}, bus.wgt_in};
    assign w_prod     = w_act_ext * w_wgt_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    assign w_fire = bus.op_valid & r_op_ready;
    assign w_pop  = bus.mem_write & ~r_empty;

`ifdef CNN_MAC_RELU_EN
    assign w_push_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    assign w_push_data = r_acc;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_tap_cnt  <= '0;
            r_op_ready <= 1'b0;
            r_mac_done <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_tap_cnt  <= w_tap_cnt_nxt;
            r_op_ready <= w_op_ready_nxt;
            r_mac_done <= w_mac_done_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state, accumulation and registered-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_tap_cnt_nxt = r_tap_cnt;
        w_push        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.mac_start && !r_full) begin
                    w_state_nxt   = S_ACCUM;
                    w_acc_nxt     = '0;
                    w_tap_cnt_nxt = '0;
                end
            end
            S_ACCUM: begin
                if (!bus.mac_start) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fire) begin
                    w_acc_nxt = r_acc + w_prod_ext;
                    if (r_tap_cnt == TAP_W'(NUM_TAPS - 1)) begin
                        w_state_nxt = S_PUSH;
                    end else begin
                        w_tap_cnt_nxt = r_tap_cnt + TAP_W'(1);
                    end
                end
            end
            S_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!bus.mac_start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_op_ready_nxt = (w_state_nxt == S_ACCUM);
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        // mac_done follows DONE by one register so the FIFO entry is visible a cycle ahead of it.
        w_mac_done_nxt = (r_state == S_DONE);
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.op_ready   = r_op_ready;
    assign bus.mac_done   = r_mac_done;
    assign bus.busy       = r_busy;
    assign bus.fifo_empty = r_empty;
    assign bus.fifo_full  = r_full;
    assign bus.result_out = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_cnn_mac_responder.sv
// Directed bench for cnn_mac_responder: dot products, abort, stall, drain, push/pop overlap, async reset.
module tb_cnn_mac_responder;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cnn_mac_if #(.DATA_W(8), .ACC_W(24)) bus ();

    cnn_mac_responder #(
        .DATA_W    (8),
        .ACC_W     (24),
        .NUM_TAPS  (9),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_res(input logic [23:0] raw);
`ifdef CNN_MAC_RELU_EN
        return raw[23] ? 24'h0 : raw;
`else
        return raw;
`endif
    endfunction

    // One full 9-tap computation; first tap uses a0/w0, the rest a/w.
    task automatic run_mac(input logic [7:0] a0, input logic [7:0] w0,
                           input logic [7:0] a, input logic [7:0] w,
                           input bit toggle, input bit pop_in_push, input bit was_empty);
        int   hs;
        int   budget;
        bit   v;
        logic rdy;
        hs = 0;
        budget = 0;
        v = 1'b1;
        bus.mac_start = 1'b1;
        while (hs < 9 && budget < 100) begin
            bus.op_valid = v;
            bus.act_in   = (hs == 0) ? a0 : a;
            bus.wgt_in   = (hs == 0) ? w0 : w;
            rdy = bus.op_ready;
            cyc();
            if (v && rdy) hs++;
            if (toggle && rdy) v = ~v;
            budget++;
        end
        bus.op_valid = 1'b0;
        chk("hs_count", 32'(hs), 32'd9);
        chk("done_t1", 32'(bus.mac_done), 32'd0);
        if (was_empty) chk("empty_t1", 32'(bus.fifo_empty), 32'd1);
        if (pop_in_push) bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;
        chk("empty_t2", 32'(bus.fifo_empty), 32'd0);
        chk("done_t2", 32'(bus.mac_done), 32'd0);
        cyc();
        chk("done_t3", 32'(bus.mac_done), 32'd1);
        cyc();
        chk("done_t4", 32'(bus.mac_done), 32'd0);
        cyc();
        cyc();
        chk("hold_ready", 32'(bus.op_ready), 32'd0);
        chk("hold_done", 32'(bus.mac_done), 32'd0);
        bus.mac_start = 1'b0;
        cyc();
        cyc();
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int hs;
        int budget;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.mac_start = 1'b0;
        bus.op_valid  = 1'b0;
        bus.act_in    = 8'h0;
        bus.wgt_in    = 8'h0;
        bus.mem_write = 1'b0;
        cyc();
        cyc();
        chk("rst_ready", 32'(bus.op_ready), 32'd0);
        chk("rst_done", 32'(bus.mac_done), 32'd0);
        chk("rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("rst_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_result", 32'(bus.result_out), 32'd0);
        rst = 1'b0;
        cyc();

        // 9 x (3 * -2) back-to-back
        run_mac(8'd3, 8'hFE, 8'd3, 8'hFE, 1'b0, 1'b0, 1'b1);
        chk("res_neg54", 32'(bus.result_out), 32'(exp_res(24'hFFFFCA)));
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;
        chk("pop_a_empty", 32'(bus.fifo_empty), 32'd1);

        // op_valid toggling, 127 * 127
        run_mac(8'd127, 8'd127, 8'd127, 8'd127, 1'b1, 1'b0, 1'b1);
        chk("res_145161", 32'(bus.result_out), 32'h023709);
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;

        // abort after 4 handshakes, op_valid kept high across the drop
        bus.mac_start = 1'b1;
        bus.op_valid  = 1'b1;
        bus.act_in    = 8'd5;
        bus.wgt_in    = 8'd7;
        hs = 0;
        budget = 0;
        while (hs < 4 && budget < 50) begin
            if (bus.op_ready) begin
                cyc();
                hs++;
            end else begin
                cyc();
            end
            budget++;
        end
        chk("abort_hs", 32'(hs), 32'd4);
        bus.mac_start = 1'b0;
        cyc();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.op_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("abort_done", 32'(bus.mac_done), 32'd0);
            chk("abort_empty", 32'(bus.fifo_empty), 32'd1);
        end
        bus.op_valid = 1'b0;
        run_mac(8'hFC, 8'd6, 8'hFC, 8'd6, 1'b0, 1'b0, 1'b1);
        chk("res_neg216", 32'(bus.result_out), 32'(exp_res(24'hFFFF28)));
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;

        // fill the FIFO with 10, 20, 30, 40
        run_mac(8'd10, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        run_mac(8'd20, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_mac(8'd30, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_mac(8'd40, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("full_after4", 32'(bus.fifo_full), 32'd1);
        chk("head_10", 32'(bus.result_out), 32'd10);
        bus.mac_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_busy", 32'(bus.busy), 32'd0);
            chk("stall_ready", 32'(bus.op_ready), 32'd0);
        end
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;
        chk("pop_head_20", 32'(bus.result_out), 32'd20);
        chk("pop_not_full", 32'(bus.fifo_full), 32'd0);
        run_mac(8'd50, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        chk("full_again", 32'(bus.fifo_full), 32'd1);

        // drain with mem_write held
        bus.mem_write = 1'b1;
        chk("drain_20", 32'(bus.result_out), 32'd20);
        cyc();
        chk("drain_30", 32'(bus.result_out), 32'd30);
        cyc();
        chk("drain_40", 32'(bus.result_out), 32'd40);
        cyc();
        chk("drain_50", 32'(bus.result_out), 32'd50);
        cyc();
        chk("drain_empty", 32'(bus.fifo_empty), 32'd1);
        cyc();
        chk("ign_empty", 32'(bus.fifo_empty), 32'd1);
        chk("ign_full", 32'(bus.fifo_full), 32'd0);
        bus.mem_write = 1'b0;

        // push and pop in the same cycle at count=2
        run_mac(8'd60, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("head_60", 32'(bus.result_out), 32'd60);
        run_mac(8'd70, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        run_mac(8'd80, 8'd1, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        chk("pp_head_70", 32'(bus.result_out), 32'd70);
        chk("pp_not_full", 32'(bus.fifo_full), 32'd0);
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;
        chk("pp_head_80", 32'(bus.result_out), 32'd80);
        chk("pp_not_empty", 32'(bus.fifo_empty), 32'd0);
        bus.mem_write = 1'b1;
        cyc();
        bus.mem_write = 1'b0;
        chk("pp_empty", 32'(bus.fifo_empty), 32'd1);

        // async reset in the middle of ACCUM with a queued result
        run_mac(8'd90, 8'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("head_90", 32'(bus.result_out), 32'd90);
        bus.mac_start = 1'b1;
        bus.op_valid  = 1'b1;
        bus.act_in    = 8'd1;
        bus.wgt_in    = 8'd1;
        cyc();
        cyc();
        cyc();
        chk("mid_ready", 32'(bus.op_ready), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(bus.op_ready), 32'd0);
        chk("arst_done", 32'(bus.mac_done), 32'd0);
        chk("arst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("arst_full", 32'(bus.fifo_full), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_result", 32'(bus.result_out), 32'd0);
        cyc();
        rst = 1'b0;
        bus.mac_start = 1'b0;
        bus.op_valid  = 1'b0;
        cyc();
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_empty", 32'(bus.fifo_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
